sram_arb2: RTL

SRAM_ARB2 -- requirements
Module: sram_arb2

---
 rtl/sram_arb_pkg.sv | 19 +
 rtl/sram_arb2_if.sv | 51 +++++
 rtl/rr_arb2.sv | 18 +
 rtl/sram_arb2.sv | 106 ++++++++++
 4 files changed

// File: rtl/sram_arb_pkg.sv
// Shared defaults and pipeline tag layout for the two-port SRAM arbiter.
package sram_arb_pkg;

  localparam int unsigned MEM_DEPTH_DEF = 1024;
  localparam int unsigned MEM_WIDTH_DEF = 32;
  localparam int unsigned MEM_BITW_DEF  = 10;

  localparam int unsigned TAG_VALID_W = 1;
  localparam int unsigned TAG_PORT_W  = 1;
  localparam int unsigned TAG_RD_W    = 1;

  // One in-flight access: occupied slot, owning port, read (expects rvalid).
  typedef struct packed {
    logic [TAG_VALID_W-1:0] valid;
    logic [TAG_PORT_W-1:0]  port;
    logic [TAG_RD_W-1:0]    is_read;
  } tag_t;

endpackage

// File: rtl/sram_arb2_if.sv
// Requester and SRAM-side signals of the two-port SRAM arbiter.
interface sram_arb2_if
  import sram_arb_pkg::*;
#(
  parameter int unsigned mem_width = MEM_WIDTH_DEF,
  parameter int unsigned mem_bitw  = MEM_BITW_DEF
);

  logic                 m0_req;
  logic                 m0_we;
  logic [mem_bitw-1:0]  m0_addr;
  logic [mem_width-1:0] m0_wdata;
  logic                 m0_gnt;
  logic                 m0_rvalid;
  logic [mem_width-1:0] m0_rdata;

  logic                 m1_req;
  logic                 m1_we;
  logic [mem_bitw-1:0]  m1_addr;
  logic [mem_width-1:0] m1_wdata;
  logic                 m1_gnt;
  logic                 m1_rvalid;
  logic [mem_width-1:0] m1_rdata;

  logic                 mem_cs;
  logic                 mem_we;
  logic [mem_bitw-1:0]  mem_addr;
  logic [mem_width-1:0] mem_din;
  logic [mem_width-1:0] mem_dout;

  // Arbiter view.
  modport slave (
    input  m0_req, m0_we, m0_addr, m0_wdata,
    input  m1_req, m1_we, m1_addr, m1_wdata,
    input  mem_dout,
    output m0_gnt, m0_rvalid, m0_rdata,
    output m1_gnt, m1_rvalid, m1_rdata,
    output mem_cs, mem_we, mem_addr, mem_din
  );

  // Requesters plus SRAM view.
  modport master (
    output m0_req, m0_we, m0_addr, m0_wdata,
    output m1_req, m1_we, m1_addr, m1_wdata,
    output mem_dout,
    input  m0_gnt, m0_rvalid, m0_rdata,
    input  m1_gnt, m1_rvalid, m1_rdata,
    input  mem_cs, mem_we, mem_addr, mem_din
  );

endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin selector; ptr holds the most recent winner.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       ptr,
  output logic [1:0] gnt
);

  // Port 0 wins unless port 1 also requests and port 0 won last.
  always_comb begin
    gnt = 2'b00;
    if (req[0] && (!req[1] || ptr)) begin
      gnt = 2'b01;
    end else if (req[1]) begin
      gnt = 2'b10;
    end
  end

endmodule

// File: rtl/sram_arb2.sv
// Two-requester round-robin arbiter in front of a single-port synchronous SRAM.
module sram_arb2
  import sram_arb_pkg::*;
#(
  parameter int unsigned mem_depth = MEM_DEPTH_DEF,
  parameter int unsigned mem_width = MEM_WIDTH_DEF,
  parameter int unsigned mem_bitw  = MEM_BITW_DEF
) (
  input  logic       clk,
  input  logic       rst,
  sram_arb2_if.slave bus
);

  if (mem_depth != (32'(1) << mem_bitw)) begin : g_depth_check
    $error("sram_arb2: mem_depth must equal 2**mem_bitw");
  end

  logic [1:0]           w_req;
  logic [1:0]           w_arb_gnt;
  logic [1:0]           w_gnt;
  logic                 w_any;
  logic                 w_win;
  logic                 w_sel_we;
  logic [mem_bitw-1:0]  w_sel_addr;
  logic [mem_width-1:0] w_sel_wdata;
  logic                 w_rvalid0;
  logic                 w_rvalid1;

  logic                 r_ptr;
  logic                 r_mem_cs;
  logic                 r_mem_we;
  logic [mem_bitw-1:0]  r_mem_addr;
  logic [mem_width-1:0] r_mem_din;
  tag_t                 r_tag1;
  tag_t                 r_tag2;
  logic [mem_width-1:0] r_rdata0;
  logic [mem_width-1:0] r_rdata1;

  assign w_req = {bus.m1_req, bus.m0_req};

  rr_arb2 u_rr_arb2 (
    .req (w_req),
    .ptr (r_ptr),
    .gnt (w_arb_gnt)
  );

  // Grants are suppressed for the whole time reset is held.
  always_comb begin
    w_gnt       = rst ? 2'b00 : w_arb_gnt;
    w_any       = |w_gnt;
    w_win       = w_gnt[1];
    w_sel_we    = w_win ? bus.m1_we    : bus.m0_we;
    w_sel_addr  = w_win ? bus.m1_addr  : bus.m0_addr;
    w_sel_wdata = w_win ? bus.m1_wdata : bus.m0_wdata;
  end

  // Launch the granted access to the SRAM and track it through two tag stages.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr      <= 1'b1;
      r_mem_cs   <= 1'b0;
      r_mem_we   <= 1'b0;
      r_mem_addr <= '0;
      r_mem_din  <= '0;
      r_tag1     <= '0;
      r_tag2     <= '0;
    end else begin
      r_mem_cs <= w_any;
      r_mem_we <= w_any & w_sel_we;
      if (w_any) begin
        r_ptr      <= w_win;
        r_mem_addr <= w_sel_addr;
        r_mem_din  <= w_sel_wdata;
      end
      r_tag1 <= '{valid: w_any, port: w_win, is_read: w_any & ~w_sel_we};
      r_tag2 <= r_tag1;
    end
  end

  assign w_rvalid0 = r_tag2.valid[0] & r_tag2.is_read[0] & ~r_tag2.port[0];
  assign w_rvalid1 = r_tag2.valid[0] & r_tag2.is_read[0] &  r_tag2.port[0];

  // Keep each port's last read word so rdata holds between rvalid pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rdata0 <= '0;
      r_rdata1 <= '0;
    end else begin
      if (w_rvalid0) r_rdata0 <= bus.mem_dout;
      if (w_rvalid1) r_rdata1 <= bus.mem_dout;
    end
  end

  // SRAM output is already registered, so the rvalid cycle forwards it directly.
  assign bus.m0_gnt    = w_gnt[0];
  assign bus.m1_gnt    = w_gnt[1];
  assign bus.m0_rvalid = w_rvalid0;
  assign bus.m1_rvalid = w_rvalid1;
  assign bus.m0_rdata  = w_rvalid0 ? bus.mem_dout : r_rdata0;
  assign bus.m1_rdata  = w_rvalid1 ? bus.mem_dout : r_rdata1;
  assign bus.mem_cs    = r_mem_cs;
  assign bus.mem_we    = r_mem_we;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_din   = r_mem_din;

endmodule
